uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the same store bus as the data memory. It is the producer of the `uartFifoFull` status bit that the data memory returns on reads of 0xFFFFFFF8.
- CPU stores to the UART data address push a byte into a TX FIFO.
- An 8N1 serializer drains the FIFO onto `tx`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_mmio.sv | 113 +++++++++++
 tb/tb_uart_tx_mmio.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and the MMIO addresses
// that the data-memory decode also uses.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [31:0] UART_STATUS_ADDR = 32'hFFFFFFF8;
  localparam logic [31:0] UART_DATA_ADDR   = 32'hFFFFFFFC;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is dropped even if a pop happens in the
// same cycle. Head data is presented combinationally on o_dout.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART TX: stores to DATA_ADDR queue a byte, an 8N1 serializer drains it.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] DATA_ADDR    = UART_DATA_ADDR
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  input  logic        wEn,
  output logic        uartFifoFull,
  output logic        tx,
  output logic        busy
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t                   r_state;
  tx_state_t                   w_state_nxt;
  logic [BW-1:0]               r_baud;
  logic [BW-1:0]               w_baud_nxt;
  logic [2:0]                  r_bit;
  logic [2:0]                  w_bit_nxt;
  logic [7:0]                  r_shift;
  logic                        r_tx;
  logic                        w_tx_nxt;
  logic                        w_tick;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [7:0]                  w_fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                        w_unused_wdata;

  assign w_unused_wdata = ^wData[31:8];
  assign w_push         = wEn && (addr == DATA_ADDR);
  assign w_pop          = (r_state == IDLE) && !w_fifo_empty;
  assign w_tick         = (r_baud == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .i_push  (w_push),
    .i_din   (wData[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_pop)  w_state_nxt = START;
      START: if (w_tick) w_state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (w_tick && r_bit == 3'd7) w_state_nxt = PARITY;
      PARITY: if (w_tick) w_state_nxt = STOP;
`else
      DATA:   if (w_tick && r_bit == 3'd7) w_state_nxt = STOP;
`endif
      STOP:    if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is computed for the state being entered so tx is a pure register.
  always_comb begin
    w_baud_nxt = (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
    w_bit_nxt  = '0;
    if (r_state == DATA) w_bit_nxt = w_tick ? r_bit + 1'b1 : r_bit;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_shift[w_bit_nxt];
      PARITY:  w_tx_nxt = ^r_shift;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_baud <= w_baud_nxt;
      r_bit  <= w_bit_nxt;
      r_tx   <= w_tx_nxt;
      if (w_pop) r_shift <= w_fifo_dout;
    end
  end

  assign tx           = r_tx;
  assign uartFifoFull = w_fifo_full;
  assign busy         = (r_state != IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=16; frames are
// sampled every cycle so each bit slot must hold its level for exactly 4 clocks.
module tb_uart_tx_mmio;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic        clk;
  logic        rstN;
  logic [31:0] addr;
  logic [31:0] wData;
  logic        wEn;
  logic        uartFifoFull;
  logic        tx;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16),
    .DATA_ADDR    (32'hFFFFFFFC)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .addr         (addr),
    .wData        (wData),
    .wEn          (wEn),
    .uartFifoFull (uartFifoFull),
    .tx           (tx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Slot 0 = start, 1..8 = data LSB first, then optional parity, then stop.
  function automatic logic [10:0] exp_slots(input logic [7:0] b);
    logic [10:0] s;
    s      = '0;
    s[0]   = 1'b0;
    s[8:1] = b;
`ifdef UART_TX_PARITY_EN
    s[9]   = ^b;
    s[10]  = 1'b1;
`else
    s[9]   = 1'b1;
`endif
    return s;
  endfunction

  // Called at a negedge; waits for the start bit, then samples every slot for CPB cycles.
  task automatic rx_frame(output logic [10:0] slots, output bit got, output int waited);
    int n;
    logic v;
    slots  = '0;
    got    = 1'b0;
    n      = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (tx !== 1'b0) return;
    got = 1'b1;
    for (int s = 0; s < NSLOT; s++) begin
      v = tx;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== v) v = 1'bx;
        @(negedge clk);
      end
      slots[s] = v;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wData = d;
    wEn   = 1'b1;
    @(negedge clk);
    wEn   = 1'b0;
    addr  = '0;
  endtask

  task automatic test_reset();
    bit stayed;
    rstN  = 1'b0;
    wEn   = 1'b1;
    addr  = UART_DATA_ADDR;
    wData = 32'h55;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++;
    if (uartFifoFull !== 1'b0) $display("FAIL reset_full: got %b expected 0", uartFifoFull); else pass_cnt++;
    wEn  = 1'b0;
    addr = '0;
    rstN = 1'b1;
    stayed = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
    end
    chk_cnt++;
    if (!stayed) $display("FAIL reset_no_queue: tx/busy moved after release, expected tx=1 busy=0");
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [10:0] slots;
    logic [10:0] exp;
    bit          got;
    int          waited;
    store(UART_DATA_ADDR, 32'h0000_00A5);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL single_busy_queued: got %b expected 1", busy); else pass_cnt++;
    chk_cnt++;
    if (tx !== 1'b1) $display("FAIL single_tx_before_pop: got %b expected 1", tx); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (tx !== 1'b0) $display("FAIL single_start_latency: got %b expected 0", tx); else pass_cnt++;
    rx_frame(slots, got, waited);
    exp = exp_slots(8'hA5);
    chk_cnt++;
    if (!got) $display("FAIL single_frame: got no start bit expected one");
    else pass_cnt++;
    for (int s = 0; s < NSLOT; s++) begin
      chk_cnt++;
      if (slots[s] !== exp[s])
        $display("FAIL single_slot%0d: got %b expected %b", s, slots[s], exp[s]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_after_stop: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [10:0] slots [17];
    bit          gots  [17];
    int          waits [17];
    bit          quiet;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          addr  = UART_DATA_ADDR;
          wData = 32'(i);
          wEn   = 1'b1;
          @(negedge clk);
          chk_cnt++;
          if (uartFifoFull !== (i >= 16))
            $display("FAIL fill_full_after_store%0d: got %b expected %b", i, uartFifoFull, (i >= 16));
          else pass_cnt++;
        end
        wEn  = 1'b0;
        addr = '0;
      end
      begin
        for (int k = 0; k < 17; k++) rx_frame(slots[k], gots[k], waits[k]);
      end
    join
    for (int k = 0; k < 17; k++) begin
      chk_cnt++;
      if (!gots[k] || slots[k] !== exp_slots(8'(k)))
        $display("FAIL fill_frame%0d: got slots %b expected %b", k, slots[k], exp_slots(8'(k)));
      else pass_cnt++;
      if (k > 0) begin
        chk_cnt++;
        if (waits[k] != 1)
          $display("FAIL fill_gap%0d: got %0d idle cycles expected 1", k, waits[k]);
        else pass_cnt++;
      end
    end
    quiet = 1'b1;
    repeat (60) begin
      if (tx !== 1'b1) quiet = 1'b0;
      @(negedge clk);
    end
    chk_cnt++;
    if (!quiet) $display("FAIL fill_dropped_0x11: got extra frame activity expected none");
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0 || uartFifoFull !== 1'b0)
      $display("FAIL fill_drained: got busy=%b full=%b expected 0 0", busy, uartFifoFull);
    else pass_cnt++;
  endtask

  task automatic test_addr_filter();
    bit quiet;
    store(UART_STATUS_ADDR, 32'h0000_0033);
    store(32'h0000_0100, 32'h0000_0044);
    quiet = 1'b1;
    repeat (20) begin
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk_cnt++;
    if (!quiet) $display("FAIL addr_filter: got tx/busy activity expected tx=1 busy=0");
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int          n;
    bit          quiet;
    logic [10:0] slots;
    bit          got;
    int          waited;
    store(UART_DATA_ADDR, 32'h0000_00F0);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB + 3 * CPB + 2) @(negedge clk);
    chk_cnt++;
    if (tx !== 1'b0) $display("FAIL midreset_bit3_level: got %b expected 0", tx); else pass_cnt++;
    rstN = 1'b0;
    #1;
    chk_cnt++;
    if (tx !== 1'b1) $display("FAIL midreset_tx_immediate: got %b expected 1", tx); else pass_cnt++;
    repeat (3) @(negedge clk);
    rstN  = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    chk_cnt++;
    if (!quiet) $display("FAIL midreset_idle_after: got activity expected tx=1 busy=0");
    else pass_cnt++;
    store(UART_DATA_ADDR, 32'h0000_003C);
    rx_frame(slots, got, waited);
    chk_cnt++;
    if (!got || slots !== exp_slots(8'h3C))
      $display("FAIL midreset_recover: got slots %b expected %b", slots, exp_slots(8'h3C));
    else pass_cnt++;
  endtask

  task automatic test_parity_bytes();
    logic [10:0] slots;
    bit          got;
    int          waited;
    store(UART_DATA_ADDR, 32'h0000_0007);
    rx_frame(slots, got, waited);
    chk_cnt++;
    if (!got || slots !== exp_slots(8'h07))
      $display("FAIL byte07_frame: got slots %b expected %b", slots, exp_slots(8'h07));
    else pass_cnt++;
`ifdef UART_TX_PARITY_EN
    chk_cnt++;
    if (slots[9] !== 1'b1) $display("FAIL parity07: got %b expected 1", slots[9]); else pass_cnt++;
`endif
    store(UART_DATA_ADDR, 32'h0000_0003);
    rx_frame(slots, got, waited);
    chk_cnt++;
    if (!got || slots !== exp_slots(8'h03))
      $display("FAIL byte03_frame: got slots %b expected %b", slots, exp_slots(8'h03));
    else pass_cnt++;
`ifdef UART_TX_PARITY_EN
    chk_cnt++;
    if (slots[9] !== 1'b0) $display("FAIL parity03: got %b expected 0", slots[9]); else pass_cnt++;
`endif
  endtask

  initial begin
    rstN  = 1'b0;
    wEn   = 1'b0;
    addr  = '0;
    wData = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_addr_filter();
    test_mid_reset();
    test_parity_bytes();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
